// File: rtl/exe_mem_stage_pkg.sv
// Shared CPU types for the EXE->MEM boundary: exception codes,
// the per-instruction bundle and the stage occupancy states.
package exe_mem_stage_pkg;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] pc;
        logic [4:0]  dst;
        logic        reg_wr;
        logic        exc_valid;
        logic [4:0]  exc_code;
        logic        in_delay_slot;
    } exe_mem_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

endpackage

// File: rtl/exe_mem_stage_skid_buf.sv
// Two-entry exe_mem_t skid buffer: output register plus one skid
// register, registered in_ready, flush empties both entries.
module exe_skid_buf
    import exe_mem_stage_pkg::*;
(
    input  logic     clk,
    input  logic     resetn,
    input  logic     flush,
    input  logic     in_valid,
    output logic     in_ready,
    input  exe_mem_t in_data,
    output logic     out_valid,
    input  logic     out_ready,
    output exe_mem_t out_data,
    output logic     skid_valid,
    output exe_mem_t skid_data
);

    stage_state_e state_q, state_d;
    exe_mem_t     out_q, out_d;
    exe_mem_t     skid_q, skid_d;
    logic         ready_q, ready_d;
    logic         valid_q, valid_d;
    logic         acc, deq;

    assign acc = in_valid & ready_q;
    assign deq = valid_q & out_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (acc) state_d = BUSY;
                BUSY: begin
                    if (acc && !deq)      state_d = FULL;
                    else if (deq && !acc) state_d = EMPTY;
                end
                FULL: if (deq) state_d = BUSY;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Data moves only when no flush; a flushed entry is never captured.
    always_comb begin
        out_d   = out_q;
        skid_d  = skid_q;
        ready_d = (state_d != FULL);
        valid_d = (state_d != EMPTY);
        if (!flush) begin
            case (state_q)
                EMPTY: if (acc) out_d = in_data;
                BUSY: begin
                    if (acc && deq) out_d = in_data;
                    else if (acc)   skid_d = in_data;
                end
                FULL: if (deq) out_d = skid_q;
                default: ;
            endcase
        end
    end

    assign in_ready   = ready_q;
    assign out_valid  = valid_q;
    assign out_data   = out_q;
    assign skid_valid = (state_q == FULL);
    assign skid_data  = skid_q;

endmodule

// File: rtl/exe_mem_stage.sv
// EXE->MEM stage: exception fold, skid-buffered handshake, forwarding.
// Define EXE_OVF_TRAP_EN to turn ALU overflow into an Ov exception.
module exe_mem_stage
    import exe_mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        exe_valid,
    output logic        exe_ready,
    input  logic [31:0] EXE_ALUOut,
    input  logic        Overflow_valid,
    input  logic [31:0] EXE_PC,
    input  logic [4:0]  EXE_Dst,
    input  logic        EXE_RegWr,
    input  logic        EXE_ExcValid,
    input  logic [4:0]  EXE_ExcCode,
    input  logic        EXE_IsInDelaySlot,
    input  logic        flush,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] MEM_ALUOut,
    output logic [31:0] MEM_PC,
    output logic [4:0]  MEM_Dst,
    output logic        MEM_RegWr,
    output logic        MEM_ExcValid,
    output logic [4:0]  MEM_ExcCode,
    output logic        MEM_IsInDelaySlot,
    input  logic [4:0]  fwd_rs,
    output logic        fwd_hit,
    output logic [31:0] fwd_data
);

    exe_mem_t in_ent, out_ent, skid_ent;
    logic     out_vld, skid_vld;
    logic     out_match, skid_match;

    // An older exception keeps its cause and always suppresses the write.
    always_comb begin
        in_ent.alu_out       = EXE_ALUOut;
        in_ent.pc            = EXE_PC;
        in_ent.dst           = EXE_Dst;
        in_ent.reg_wr        = EXE_RegWr;
        in_ent.exc_valid     = EXE_ExcValid;
        in_ent.exc_code      = EXE_ExcCode;
        in_ent.in_delay_slot = EXE_IsInDelaySlot;
        if (EXE_ExcValid) begin
            in_ent.reg_wr = 1'b0;
        end
`ifdef EXE_OVF_TRAP_EN
        else if (Overflow_valid) begin
            in_ent.exc_valid = 1'b1;
            in_ent.exc_code  = EXC_OV;
            in_ent.reg_wr    = 1'b0;
        end
`endif
    end

`ifndef EXE_OVF_TRAP_EN
    logic ovf_unused;
    assign ovf_unused = Overflow_valid;
`endif

    exe_skid_buf u_buf (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .in_valid   (exe_valid),
        .in_ready   (exe_ready),
        .in_data    (in_ent),
        .out_valid  (out_vld),
        .out_ready  (mem_ready),
        .out_data   (out_ent),
        .skid_valid (skid_vld),
        .skid_data  (skid_ent)
    );

    assign mem_valid         = out_vld;
    assign MEM_ALUOut        = out_ent.alu_out;
    assign MEM_PC            = out_ent.pc;
    assign MEM_Dst           = out_ent.dst;
    assign MEM_RegWr         = out_ent.reg_wr;
    assign MEM_ExcValid      = out_ent.exc_valid;
    assign MEM_ExcCode       = out_ent.exc_code;
    assign MEM_IsInDelaySlot = out_ent.in_delay_slot;

    assign out_match = out_vld && out_ent.reg_wr && !out_ent.exc_valid
                    && (out_ent.dst == fwd_rs) && (fwd_rs != 5'd0);
    assign skid_match = skid_vld && skid_ent.reg_wr && !skid_ent.exc_valid
                     && (skid_ent.dst == fwd_rs) && (fwd_rs != 5'd0);

    // The skid entry is younger, so its value is the architecturally newest.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = 32'd0;
        if (skid_match) begin
            fwd_hit  = 1'b1;
            fwd_data = skid_ent.alu_out;
        end else if (out_match) begin
            fwd_hit  = 1'b1;
            fwd_data = out_ent.alu_out;
        end
    end

endmodule

// File: tb/tb_exe_mem_stage.sv
// Self-checking bench for exe_mem_stage: directed vector table plus
// randomized traffic checked against a queue-based reference model.
module tb_exe_mem_stage;

`ifdef EXE_OVF_TRAP_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        exe_valid;
    logic        exe_ready;
    logic [31:0] EXE_ALUOut;
    logic        Overflow_valid;
    logic [31:0] EXE_PC;
    logic [4:0]  EXE_Dst;
    logic        EXE_RegWr;
    logic        EXE_ExcValid;
    logic [4:0]  EXE_ExcCode;
    logic        EXE_IsInDelaySlot;
    logic        flush;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] MEM_ALUOut;
    logic [31:0] MEM_PC;
    logic [4:0]  MEM_Dst;
    logic        MEM_RegWr;
    logic        MEM_ExcValid;
    logic [4:0]  MEM_ExcCode;
    logic        MEM_IsInDelaySlot;
    logic [4:0]  fwd_rs;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    always #5 clk = ~clk;

    exe_mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .exe_valid         (exe_valid),
        .exe_ready         (exe_ready),
        .EXE_ALUOut        (EXE_ALUOut),
        .Overflow_valid    (Overflow_valid),
        .EXE_PC            (EXE_PC),
        .EXE_Dst           (EXE_Dst),
        .EXE_RegWr         (EXE_RegWr),
        .EXE_ExcValid      (EXE_ExcValid),
        .EXE_ExcCode       (EXE_ExcCode),
        .EXE_IsInDelaySlot (EXE_IsInDelaySlot),
        .flush             (flush),
        .mem_valid         (mem_valid),
        .mem_ready         (mem_ready),
        .MEM_ALUOut        (MEM_ALUOut),
        .MEM_PC            (MEM_PC),
        .MEM_Dst           (MEM_Dst),
        .MEM_RegWr         (MEM_RegWr),
        .MEM_ExcValid      (MEM_ExcValid),
        .MEM_ExcCode       (MEM_ExcCode),
        .MEM_IsInDelaySlot (MEM_IsInDelaySlot),
        .fwd_rs            (fwd_rs),
        .fwd_hit           (fwd_hit),
        .fwd_data          (fwd_data)
    );

    typedef struct {
        logic [31:0] alu;
        logic [31:0] pc;
        logic [4:0]  dst;
        logic        rw;
        logic        excv;
        logic [4:0]  excc;
        logic        ds;
    } ent_t;

    typedef struct {
        bit          v;
        logic [31:0] alu;
        logic [4:0]  dst;
        bit          rw;
        bit          ovf;
        bit          excv;
        logic [4:0]  excc;
        bit          fl;
        bit          mr;
        logic [4:0]  rs;
        bit          e_mv;
        bit          e_rdy;
        logic [31:0] e_alu;
        bit          e_fh;
        logic [31:0] e_fd;
    } row_t;

    ent_t        q[$];
    bit          mdl_ready;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] pc_ctr = 32'h0000_1000;
    row_t        tbl[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ent_t fold_in();
        ent_t e;
        e.alu  = EXE_ALUOut;
        e.pc   = EXE_PC;
        e.dst  = EXE_Dst;
        e.rw   = EXE_RegWr;
        e.excv = EXE_ExcValid;
        e.excc = EXE_ExcCode;
        e.ds   = EXE_IsInDelaySlot;
        if (EXE_ExcValid) begin
            e.rw = 1'b0;
        end else if (OVF_ON && Overflow_valid) begin
            e.excv = 1'b1;
            e.excc = 5'h0C;
            e.rw   = 1'b0;
        end
        return e;
    endfunction

    task automatic model_check();
        bit          hit = 1'b0;
        logic [31:0] data = 32'd0;
        chk("exe_ready", {31'd0, exe_ready}, {31'd0, mdl_ready});
        chk("mem_valid", {31'd0, mem_valid}, {31'd0, q.size() > 0});
        if (q.size() > 0) begin
            chk("MEM_ALUOut", MEM_ALUOut, q[0].alu);
            chk("MEM_PC", MEM_PC, q[0].pc);
            chk("MEM_Dst", {27'd0, MEM_Dst}, {27'd0, q[0].dst});
            chk("MEM_RegWr", {31'd0, MEM_RegWr}, {31'd0, q[0].rw});
            chk("MEM_ExcValid", {31'd0, MEM_ExcValid}, {31'd0, q[0].excv});
            chk("MEM_ExcCode", {27'd0, MEM_ExcCode}, {27'd0, q[0].excc});
            chk("MEM_DelaySlot", {31'd0, MEM_IsInDelaySlot}, {31'd0, q[0].ds});
        end
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (!hit && fwd_rs != 5'd0 && q[i].rw && !q[i].excv
                && q[i].dst == fwd_rs) begin
                hit  = 1'b1;
                data = q[i].alu;
            end
        end
        chk("fwd_hit", {31'd0, fwd_hit}, {31'd0, hit});
        chk("fwd_data", fwd_data, data);
    endtask

    task automatic model_edge();
        bit acc;
        bit deq;
        if (!resetn) begin
            q.delete();
            mdl_ready = 1'b0;
        end else begin
            acc = exe_valid && mdl_ready;
            deq = (q.size() > 0) && mem_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (deq) void'(q.pop_front());
                if (acc) q.push_back(fold_in());
            end
            mdl_ready = (q.size() < 2);
        end
    endtask

    task automatic cycle(input row_t r, input bit use_tbl);
        @(negedge clk);
        exe_valid         = r.v;
        EXE_ALUOut        = r.alu;
        EXE_Dst           = r.dst;
        EXE_RegWr         = r.rw;
        Overflow_valid    = r.ovf;
        EXE_ExcValid      = r.excv;
        EXE_ExcCode       = r.excc;
        flush             = r.fl;
        mem_ready         = r.mr;
        fwd_rs            = r.rs;
        EXE_PC            = pc_ctr;
        EXE_IsInDelaySlot = pc_ctr[2];
        pc_ctr            = pc_ctr + 32'd4;
        #1;
        model_check();
        if (use_tbl) begin
            chk("tbl_mem_valid", {31'd0, mem_valid}, {31'd0, r.e_mv});
            chk("tbl_exe_ready", {31'd0, exe_ready}, {31'd0, r.e_rdy});
            if (r.e_mv) chk("tbl_MEM_ALUOut", MEM_ALUOut, r.e_alu);
            chk("tbl_fwd_hit", {31'd0, fwd_hit}, {31'd0, r.e_fh});
            chk("tbl_fwd_data", fwd_data, r.e_fd);
        end
        @(posedge clk);
        model_edge();
    endtask

    function automatic row_t mk(
        bit v, logic [31:0] alu, logic [4:0] dst, bit rw, bit ovf,
        bit excv, logic [4:0] excc, bit fl, bit mr, logic [4:0] rs,
        bit e_mv, bit e_rdy, logic [31:0] e_alu, bit e_fh, logic [31:0] e_fd);
        row_t r;
        r.v = v; r.alu = alu; r.dst = dst; r.rw = rw; r.ovf = ovf;
        r.excv = excv; r.excc = excc; r.fl = fl; r.mr = mr; r.rs = rs;
        r.e_mv = e_mv; r.e_rdy = e_rdy; r.e_alu = e_alu;
        r.e_fh = e_fh; r.e_fd = e_fd;
        return r;
    endfunction

    initial begin
        row_t        r;
        bit          ovf_fh;
        logic [31:0] ovf_fd;

        ovf_fh = !OVF_ON;
        ovf_fd = OVF_ON ? 32'd0 : 32'h8000_0000;

        // streaming
        tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 2, 1, 1, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(1, 3, 1, 1, 0, 0, 0, 0, 1, 0, 1, 1, 2, 0, 0));
        tbl.push_back(mk(1, 4, 1, 1, 0, 0, 0, 0, 1, 0, 1, 1, 3, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 4, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
        // back-pressure into FULL, then drain
        tbl.push_back(mk(1, 'hA, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 'hB, 3, 1, 0, 0, 0, 0, 0, 0, 1, 1, 'hA, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'hA, 0, 0));
        tbl.push_back(mk(1, 'hC, 6, 1, 0, 0, 0, 0, 0, 0, 1, 0, 'hA, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0, 'hA, 1, 'hB));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 1, 'hB, 1, 'hB));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 1, 0, 0, 0));
        // overflow
        tbl.push_back(mk(1, 32'h8000_0000, 8, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 1, 1, 32'h8000_0000, ovf_fh, ovf_fd));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 1, 1, 32'h8000_0000, ovf_fh, ovf_fd));
        // upstream exception beats overflow
        tbl.push_back(mk(1, 5, 9, 1, 1, 1, 4, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 1, 1, 5, 0, 0));
        // flush in FULL with exe_valid
        tbl.push_back(mk(1, 'h31, 4, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 'h32, 4, 1, 0, 0, 0, 0, 0, 0, 1, 1, 'h31, 0, 0));
        tbl.push_back(mk(1, 'h33, 4, 1, 0, 0, 0, 1, 0, 0, 1, 0, 'h31, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 1, 0, 0, 0));
        // flush with same-cycle accept and dequeue
        tbl.push_back(mk(1, 'h41, 4, 1, 0, 0, 0, 0, 0, 4, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 'h42, 4, 1, 0, 0, 0, 1, 1, 4, 1, 1, 'h41, 1, 'h41));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 1, 0, 0, 0));
        // forwarding priority
        tbl.push_back(mk(1, 'h11, 5, 1, 0, 0, 0, 0, 0, 5, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 'h22, 5, 1, 0, 0, 0, 0, 0, 5, 1, 1, 'h11, 1, 'h11));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 'h11, 1, 'h22));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'h11, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 1, 0, 'h11, 1, 'h22));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 1, 1, 'h22, 1, 'h22));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 1, 0, 0, 0));

        resetn = 1'b0; exe_valid = 1'b0; EXE_ALUOut = '0;
        Overflow_valid = 1'b0; EXE_PC = '0; EXE_Dst = '0;
        EXE_RegWr = 1'b0; EXE_ExcValid = 1'b0; EXE_ExcCode = '0;
        EXE_IsInDelaySlot = 1'b0; flush = 1'b0; mem_ready = 1'b0;
        fwd_rs = 5'd5; mdl_ready = 1'b0;

        repeat (2) begin
            @(posedge clk);
            model_edge();
        end
        @(negedge clk);
        #1;
        chk("rst_exe_ready", {31'd0, exe_ready}, 32'd0);
        chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_MEM_ALUOut", MEM_ALUOut, 32'd0);
        chk("rst_MEM_PC", MEM_PC, 32'd0);
        chk("rst_MEM_Dst", {27'd0, MEM_Dst}, 32'd0);
        chk("rst_MEM_RegWr", {31'd0, MEM_RegWr}, 32'd0);
        chk("rst_MEM_ExcValid", {31'd0, MEM_ExcValid}, 32'd0);
        chk("rst_MEM_ExcCode", {27'd0, MEM_ExcCode}, 32'd0);
        chk("rst_fwd_hit", {31'd0, fwd_hit}, 32'd0);
        chk("rst_fwd_data", fwd_data, 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        model_edge();

        foreach (tbl[i]) cycle(tbl[i], 1'b1);

        for (int n = 0; n < 600; n++) begin
            r.v    = ($urandom_range(0, 9) < 7);
            r.alu  = $urandom;
            r.dst  = 5'($urandom_range(0, 7));
            r.rw   = ($urandom_range(0, 3) != 0);
            r.ovf  = ($urandom_range(0, 3) == 0);
            r.excv = ($urandom_range(0, 7) == 0);
            r.excc = 5'($urandom_range(0, 31));
            r.fl   = ($urandom_range(0, 15) == 0);
            r.mr   = ($urandom_range(0, 9) < 6);
            r.rs   = 5'($urandom_range(0, 7));
            r.e_mv = 1'b0; r.e_rdy = 1'b0; r.e_alu = '0;
            r.e_fh = 1'b0; r.e_fd = '0;
            cycle(r, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exe_mem_stage.md
# exe_mem_stage

EXE→MEM pipeline stage register for the MIPS core. Captures the ALU result, overflow flag and per-instruction sideband from the EXE stage. Folds arithmetic overflow into the precise-exception fields and presents the instruction to MEM through a valid/ready handshake. A two-entry skid buffer keeps EXE ready registered, and a query port forwards in-flight results back to the operand mux.

## Interface
- No parameters; widths are fixed by the shared CPU package.
- clk  in  1  core clock; all state updates on rising edge
- resetn  in  1  synchronous, active-low reset
- exe_valid  in  1  EXE presents an instruction
- exe_ready  out  1  stage can accept; 0 while resetn=0 or state=FULL
- EXE_ALUOut  in  32  ALU result
- Overflow_valid  in  1  ALU signed overflow (ADD/SUB only)
- EXE_PC  in  32  instruction PC
- EXE_Dst  in  5  destination GPR
- EXE_RegWr  in  1  GPR write enable
- EXE_ExcValid  in  1  exception already raised upstream
- EXE_ExcCode  in  5  upstream exception code
- EXE_IsInDelaySlot  in  1  branch delay slot flag
- flush  in  1  CP0 exception/ERET flush; kills all held entries
- mem_valid  out  1  MEM output entry valid
- mem_ready  in  1  MEM accepts this cycle
- MEM_ALUOut, MEM_PC  out  32 each  held result / PC
- MEM_Dst  out  5; MEM_RegWr  out  1; MEM_ExcValid  out  1; MEM_ExcCode  out  5; MEM_IsInDelaySlot  out  1
- fwd_rs  in  5  register being queried by the operand mux
- fwd_hit  out  1  a held entry writes fwd_rs
- fwd_data  out  32  value for fwd_rs

## Operation
- States: EMPTY (no entry), BUSY (output register full), FULL (output and skid registers full).
- Transfers: acc = exe_valid & exe_ready; deq = mem_valid & mem_ready.
- EMPTY: acc → BUSY.
- BUSY: acc & ~deq → FULL, new entry into the skid register. deq & ~acc → EMPTY. acc & deq → BUSY, new entry into the output register.
- FULL: deq → BUSY, skid entry moves to the output register. exe_ready=0.
- Exception fold on capture:
  - EXE_ExcValid=1 → its code is kept (older cause wins) and RegWr is forced to 0.
  - Otherwise, overflow per Configuration.
- flush=1: next state EMPTY, both entries invalidated, and any same-cycle acc is discarded. flush has priority over every other event.
- Forwarding:
  - fwd_hit requires fwd_rs≠0 and an entry that is valid, has RegWr=1, has ExcValid=0 and has Dst==fwd_rs.
  - When both entries match, the skid (younger) entry wins.
  - fwd_data=0 when fwd_hit=0.

## Timing
- Reset: state EMPTY, mem_valid=0, exe_ready=0 during reset and 1 on the first cycle after, all MEM_* outputs and fwd_* outputs 0.
- Latency: an entry accepted at edge N is visible on mem_valid at N+1.
- Throughput: 1 per cycle while mem_ready=1.
- exe_ready, mem_valid and MEM_* are register outputs only. fwd_hit and fwd_data are combinational from registers plus fwd_rs.
- MEM_* stay stable while mem_valid=1 and mem_ready=0.
- Simultaneous flush and deq: MEM still samples the current entry; the stage goes EMPTY.

## Configuration
- `EXE_OVF_TRAP_EN` defined: Overflow_valid=1 with EXE_ExcValid=0 sets ExcValid=1, ExcCode=5'h0C (Ov) and RegWr=0.
- `EXE_OVF_TRAP_EN` undefined: Overflow_valid is ignored; RegWr and the exception fields pass through unchanged.

## Structure
- Shared CPU package holds:
  - exception-code constants (EXC_OV=5'h0C, etc.)
  - packed struct exe_mem_t (ALUOut, PC, Dst, RegWr, ExcValid, ExcCode, IsInDelaySlot)
  - state enum {EMPTY, BUSY, FULL}
- Sub-module `exe_skid_buf`: generic two-entry exe_mem_t skid buffer with flush. The top level does the exception fold and forwarding compare.

## Test plan
- Streaming: 4 back-to-back accepts with mem_ready=1 (results 1..4) → mem_valid from cycle 1, results 1,2,3,4 on consecutive cycles, exe_ready always 1.
- Back-pressure: mem_ready=0 with 2 accepts (0xA, 0xB) → FULL, exe_ready=0, MEM_ALUOut holds 0xA. Raise mem_ready → 0xA then 0xB, no loss or duplication.
- Overflow, macro on: ALUOut=0x80000000 with Overflow_valid=1, Dst=8 → MEM_ExcValid=1, ExcCode=0x0C, RegWr=0, fwd_rs=8 gives fwd_hit=0. Macro off: ExcValid=0, RegWr=1, fwd_hit=1, fwd_data=0x80000000.
- Exception priority: EXE_ExcValid=1 with code 0x04 plus Overflow_valid=1 → MEM_ExcCode=0x04.
- Flush: in FULL, flush=1 together with exe_valid=1 → next cycle EMPTY, mem_valid=0, exe_ready=1, and the flushed instruction never appears.
- Forward priority: both entries write Dst=5 (0x11 older, 0x22 younger), fwd_rs=5 → fwd_data=0x22; fwd_rs=0 → fwd_hit=0.
